pipelined_barrel_shifter: RTL and testbench
===========================================

Name: pipelined_barrel_shifter

Overview:
- Parametrised, pipelined successor to the team's combinational 32-bit barrel shifter used in the EX-stage ALU.
- Performs arithmetic right, logical right, logical left and rotate right on WIDTH-bit operands, and produces a carry-out.
- The log2(WIDTH) shift levels are split across STAGES register stages, with a valid/ready handshake and a synchronous flush.
- Sits between the ALU operand muxes and the writeback/flag logic; supports back-to-back issue at one operation per cycle.

Parameters:
- WIDTH, 32, operand width; must be a power of 2, at least 8.
- STAGES, 2, number of register stages (1..$clog2(WIDTH)); equals the latency.
- SHW, $clog2(WIDTH), shift-amount width; derived, not to be overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipeline kill; highest priority after reset.
- in_valid  in  1  input operation valid.
- in_ready  out  1  shifter can accept an operation this cycle.
- a  in  WIDTH  operand to shift.
- b  in  SHW  shift amount.
- alu  in  2  mode: 00 SRA, 01 SRL, 10 SLL, 11 ROR.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- c  out  WIDTH  shifted result.
- carry  out  1  last bit shifted or rotated out.

Behaviour:
- Reset (async, rst_n=0): all stage valid bits 0, data/carry/mode registers 0. Outputs: out_valid=0, c=0, carry=0; in_ready=1 once rst_n deasserts.
- Level k (k=0..SHW-1) shifts by 2^k when b[k]=1. Levels are assigned to stages in order, ceil(SHW/STAGES) per stage; the last stage may hold fewer. Each stage ends in a register, and the final register drives c/carry directly.
- Latency: an op accepted at edge N appears with out_valid=1 after edge N+STAGES-1, i.e. visible in cycle N+STAGES.
- Handshake:
  - advance = !out_valid || out_ready; in_ready = advance.
  - All stages move together when advance=1 and hold when advance=0.
  - Accept occurs when in_valid && in_ready.
  - Bubbles propagate as valid=0.
  - Throughput is 1 op/cycle with out_ready tied high.
- Stall: while out_valid && !out_ready, c, carry and out_valid hold stable and in_ready=0.
- Fill modes:
  - SRA fills vacated MSBs with the original a[WIDTH-1]; the sign bit is carried down the pipe.
  - SRL and SLL fill with 0.
  - ROR rotates with no fill.
- Carry per level when the level's bit is set:
  - right shifts: carry = stage input bit [2^k-1].
  - SLL: carry = stage input bit [WIDTH-2^k].
  - Carry is otherwise passed through, starting at 0.
  - ROR: carry = final c[WIDTH-1] when b!=0.
- Boundaries:
  - b=0: c=a and carry=0 for every mode.
  - b=WIDTH-1 is the maximum shift; there is no out-of-range case.
  - SRA of a negative operand by WIDTH-1 gives all ones.
- flush=1 at an edge clears all valid bits; data registers may keep stale values. flush has priority over accept and advance, so an op offered in the same cycle is dropped; in_ready is unaffected.
- Reset mid-operation discards all in-flight ops immediately.
- Mode, sign and carry travel with their op, so mixed modes back-to-back are legal.

Decomposition:
- Shared package alu_pkg:
  - mode localparams ALU_SRA=2'b00, ALU_SRL=2'b01, ALU_SLL=2'b10, ALU_ROR=2'b11. These are shared with the ALU decoder.
- One sub-module, shift_level: a combinational single level parametrised by WIDTH and a shift distance. It takes data, mode, enable, fill bit and carry_in, and produces data and carry_out.
- The top instantiates SHW shift_level blocks in a generate loop and inserts stage registers plus valid bits at the level boundaries.

Test Plan:
- WIDTH=32, STAGES=2, out_ready=1; a=0x80000001, b=1, alu=00 -> two cycles later c=0xC0000000, carry=1, out_valid pulse of one cycle.
- a=0x80000001, b=1, alu=01 -> c=0x40000000, carry=1; same operand, alu=10 -> c=0x00000002, carry=1; alu=11 -> c=0xC0000000, carry=1.
- b=0 on 0xDEADBEEF in all four modes -> c=0xDEADBEEF, carry=0; SRA of 0x80000000 with b=31 -> c=0xFFFFFFFF, carry=0.
- Stream of 8 back-to-back ops with mixed modes, then out_ready=0 for 3 cycles mid-stream -> in_ready=0 while held, c stable, no op lost or duplicated, order preserved.
- Two ops in flight, assert flush for 1 cycle with in_valid=1 -> neither in-flight op nor the offered op ever produces out_valid; the next op is accepted normally with full latency.
- rst_n pulsed low asynchronously mid-stream between clock edges -> out_valid=0, c=0, carry=0 immediately; sweep STAGES=1..5 on random vectors against a reference model.

Source files
------------

// File: rtl/alu_pkg.sv
// ALU mode encodings shared between the ALU decoder and the pipelined shifter.
package alu_pkg;

  localparam logic [1:0] ALU_SRA = 2'b00;
  localparam logic [1:0] ALU_SRL = 2'b01;
  localparam logic [1:0] ALU_SLL = 2'b10;
  localparam logic [1:0] ALU_ROR = 2'b11;

  function automatic logic is_right_mode(input logic [1:0] mode);
    return (mode != ALU_SLL);
  endfunction

endpackage

// File: rtl/pipelined_barrel_shifter_if.sv
// Operation/result handshake bundle between the ALU operand muxes, the shifter and writeback.
interface pipelined_barrel_shifter_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [SHW-1:0]   b;
  logic [1:0]       alu;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] c;
  logic             carry;

  modport master (
    output in_valid, a, b, alu, out_ready,
    input  in_ready, out_valid, c, carry
  );

  modport slave (
    input  in_valid, a, b, alu, out_ready,
    output in_ready, out_valid, c, carry
  );
endinterface

// File: rtl/shift_level.sv
// One combinational barrel-shifter level: optionally shifts/rotates by DIST and updates carry.
module shift_level
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] din,
  input  logic [1:0]       mode,
  input  logic             en,
  input  logic             fill,
  input  logic             carry_in,
  output logic [WIDTH-1:0] dout,
  output logic             carry_out
);

  logic fill_bit;

  always_comb begin
    dout      = din;
    carry_out = carry_in;
    fill_bit  = (mode == ALU_SRA) ? fill : 1'b0;
    if (en) begin
      if (mode == ALU_SLL) begin
        dout      = {din[WIDTH-DIST-1:0], {DIST{1'b0}}};
        carry_out = din[WIDTH-DIST];
      end else if (mode == ALU_ROR) begin
        dout      = {din[DIST-1:0], din[WIDTH-1:DIST]};
        carry_out = din[DIST-1];
      end else if (is_right_mode(mode)) begin
        dout      = {{DIST{fill_bit}}, din[WIDTH-1:DIST]};
        carry_out = din[DIST-1];
      end
    end
  end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined SRA/SRL/SLL/ROR barrel shifter with carry-out, valid/ready handshake and flush.
module pipelined_barrel_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int SHW    = $clog2(WIDTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  pipelined_barrel_shifter_if.slave bus
);

  // Levels per stage; trailing stages may end up with no levels and act as plain delay.
  localparam int LPS = (SHW + STAGES - 1) / STAGES;

  logic             advance;
  logic             accept;

  logic             v_in  [STAGES];
  logic [WIDTH-1:0] d_in  [STAGES];
  logic             cy_in [STAGES];
  logic             sg_in [STAGES];
  logic [1:0]       md_in [STAGES];
  logic [SHW-1:0]   b_in  [STAGES];

  logic             v_reg  [STAGES];
  logic [WIDTH-1:0] d_reg  [STAGES];
  logic             cy_reg [STAGES];
  logic             sg_reg [STAGES];
  logic [1:0]       md_reg [STAGES];
  logic [SHW-1:0]   b_reg  [STAGES];

  logic [WIDTH-1:0] ch_d  [STAGES][LPS+1];
  logic             ch_cy [STAGES][LPS+1];

  assign advance      = !v_reg[STAGES-1] || bus.out_ready;
  assign accept       = bus.in_valid && advance;
  assign bus.in_ready = advance;

  assign bus.out_valid = v_reg[STAGES-1];
  assign bus.c         = d_reg[STAGES-1];
  assign bus.carry     = cy_reg[STAGES-1];

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign v_in[gi]  = accept;
        assign d_in[gi]  = bus.a;
        assign cy_in[gi] = 1'b0;
        assign sg_in[gi] = bus.a[WIDTH-1];
        assign md_in[gi] = bus.alu;
        assign b_in[gi]  = bus.b;
      end else begin : g_link
        assign v_in[gi]  = v_reg[gi-1];
        assign d_in[gi]  = d_reg[gi-1];
        assign cy_in[gi] = cy_reg[gi-1];
        assign sg_in[gi] = sg_reg[gi-1];
        assign md_in[gi] = md_reg[gi-1];
        assign b_in[gi]  = b_reg[gi-1];
      end

      assign ch_d[gi][0]  = d_in[gi];
      assign ch_cy[gi][0] = cy_in[gi];

      for (genvar gj = 0; gj < LPS; gj++) begin : g_level
        localparam int K = gi * LPS + gj;
        if (K < SHW) begin : g_shift
          shift_level #(
            .WIDTH (WIDTH),
            .DIST  (1 << K)
          ) u_level (
            .din       (ch_d[gi][gj]),
            .mode      (md_in[gi]),
            .en        (b_in[gi][K]),
            .fill      (sg_in[gi]),
            .carry_in  (ch_cy[gi][gj]),
            .dout      (ch_d[gi][gj+1]),
            .carry_out (ch_cy[gi][gj+1])
          );
        end else begin : g_pass
          assign ch_d[gi][gj+1]  = ch_d[gi][gj];
          assign ch_cy[gi][gj+1] = ch_cy[gi][gj];
        end
      end
    end
  endgenerate

  // Flush only kills valid bits; payload registers keep following advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) begin
        v_reg[s]  <= 1'b0;
        d_reg[s]  <= '0;
        cy_reg[s] <= 1'b0;
        sg_reg[s] <= 1'b0;
        md_reg[s] <= '0;
        b_reg[s]  <= '0;
      end
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (flush) begin
          v_reg[s] <= 1'b0;
        end else if (advance) begin
          v_reg[s] <= v_in[s];
        end
        if (advance) begin
          d_reg[s]  <= ch_d[s][LPS];
          cy_reg[s] <= ch_cy[s][LPS];
          sg_reg[s] <= sg_in[s];
          md_reg[s] <= md_in[s];
          b_reg[s]  <= b_in[s];
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed bench for pipelined_barrel_shifter plus a STAGES=1..5 sweep against a behavioural model.
module tb_pipelined_barrel_shifter;
  import alu_pkg::*;

  localparam int WIDTH = 32;
  localparam int SHW   = 5;
  localparam int NSW   = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic flush = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipelined_barrel_shifter_if #(.WIDTH(WIDTH)) bus ();

  pipelined_barrel_shifter #(.WIDTH(WIDTH), .STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  logic             sw_valid = 1'b0;
  logic [WIDTH-1:0] sw_a     = '0;
  logic [SHW-1:0]   sw_b     = '0;
  logic [1:0]       sw_alu   = '0;
  logic             sw_ov [NSW];
  logic [WIDTH-1:0] sw_c  [NSW];
  logic             sw_cy [NSW];
  logic             sw_ir [NSW];

  generate
    for (genvar gi = 0; gi < NSW; gi++) begin : g_sweep
      pipelined_barrel_shifter_if #(.WIDTH(WIDTH)) sif ();
      assign sif.in_valid  = sw_valid;
      assign sif.a         = sw_a;
      assign sif.b         = sw_b;
      assign sif.alu       = sw_alu;
      assign sif.out_ready = 1'b1;
      pipelined_barrel_shifter #(.WIDTH(WIDTH), .STAGES(gi + 1)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (1'b0),
        .bus   (sif)
      );
      assign sw_ov[gi] = sif.out_valid;
      assign sw_c[gi]  = sif.c;
      assign sw_cy[gi] = sif.carry;
      assign sw_ir[gi] = sif.in_ready;
    end
  endgenerate

  // Bit-level reference: {carry, c}
  function automatic logic [WIDTH:0] ref_shift(input logic [WIDTH-1:0] a,
                                               input logic [SHW-1:0] b,
                                               input logic [1:0] m);
    logic [2*WIDTH-1:0] w;
    logic [WIDTH-1:0]   r;
    logic               cy;
    int                 bi;
    bi = int'(b);
    w  = {a, a} >> bi;
    case (m)
      ALU_SRA: r = $signed(a) >>> bi;
      ALU_SRL: r = a >> bi;
      ALU_SLL: r = a << bi;
      default: r = w[WIDTH-1:0];
    endcase
    if (bi == 0)          cy = 1'b0;
    else if (m == ALU_SLL) cy = a[WIDTH-bi];
    else                   cy = a[bi-1];
    return {cy, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.alu       = '0;
    bus.out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_tests++;
    if (bus.c !== 32'h0) begin n_fail++; $display("FAIL reset_c: got %h want 00000000", bus.c); end
    n_tests++;
    if (bus.carry !== 1'b0) begin n_fail++; $display("FAIL reset_carry: got %b want 0", bus.carry); end
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    $display("[TB] reset: done");
  endtask

  task automatic test_modes();
    logic [1:0]       op_m [4];
    logic [WIDTH-1:0] exp_c [4];
    logic             exp_cy [4];
    int               lat;
    op_m   = '{ALU_SRA, ALU_SRL, ALU_SLL, ALU_ROR};
    exp_c  = '{32'hC0000000, 32'h40000000, 32'h00000002, 32'hC0000000};
    exp_cy = '{1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      bus.a = 32'h80000001; bus.b = 5'd1; bus.alu = op_m[i]; bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 8) begin tick(); lat++; end
      n_tests++;
      if (lat != 1) begin n_fail++; $display("FAIL mode%0d_latency: got %0d extra edges want 1", i, lat); end
      n_tests++;
      if (bus.c !== exp_c[i] || bus.carry !== exp_cy[i]) begin
        n_fail++; $display("FAIL mode%0d_result: got c=%h carry=%b want c=%h carry=%b", i, bus.c, bus.carry, exp_c[i], exp_cy[i]);
      end
      tick();
      n_tests++;
      if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mode%0d_pulse: out_valid still %b want 0", i, bus.out_valid); end
      $display("[TB] mode alu=%0d a=80000001 b=1 -> c=%h carry=%b", op_m[i], exp_c[i], exp_cy[i]);
    end
  endtask

  task automatic test_boundaries();
    logic [WIDTH-1:0] op_a [5];
    logic [SHW-1:0]   op_b [5];
    logic [1:0]       op_m [5];
    logic [WIDTH-1:0] exp_c [5];
    logic             exp_cy [5];
    int               lat;
    op_a   = '{32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'h80000000};
    op_b   = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd31};
    op_m   = '{ALU_SRA, ALU_SRL, ALU_SLL, ALU_ROR, ALU_SRA};
    exp_c  = '{32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hFFFFFFFF};
    exp_cy = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      bus.a = op_a[i]; bus.b = op_b[i]; bus.alu = op_m[i]; bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 8) begin tick(); lat++; end
      n_tests++;
      if (lat != 1 || bus.c !== exp_c[i] || bus.carry !== exp_cy[i]) begin
        n_fail++; $display("FAIL bound%0d: got lat=%0d c=%h carry=%b want lat=1 c=%h carry=%b", i, lat, bus.c, bus.carry, exp_c[i], exp_cy[i]);
      end
      tick();
      $display("[TB] boundary a=%h b=%0d alu=%0d -> c=%h carry=%b", op_a[i], op_b[i], op_m[i], exp_c[i], exp_cy[i]);
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] op_a [8];
    logic [SHW-1:0]   op_b [8];
    logic [1:0]       op_m [8];
    logic [WIDTH-1:0] exp_c [8];
    logic             exp_cy [8];
    logic [WIDTH-1:0] held_c;
    logic             held_cy;
    bit               holding;
    bit               acc;
    int               tx, rx, stalls;
    op_a   = '{32'h000000F0, 32'h0000000F, 32'h80000000, 32'h00000001,
               32'h12345678, 32'hFFFF0000, 32'h00000003, 32'hF0000000};
    op_b   = '{5'd4, 5'd4, 5'd4, 5'd1, 5'd8, 5'd16, 5'd2, 5'd28};
    op_m   = '{ALU_SRL, ALU_SLL, ALU_SRA, ALU_ROR, ALU_ROR, ALU_SLL, ALU_SRL, ALU_SRA};
    exp_c  = '{32'h0000000F, 32'h000000F0, 32'hF8000000, 32'h80000000,
               32'h78123456, 32'h00000000, 32'h00000000, 32'hFFFFFFFF};
    exp_cy = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tx = 0; rx = 0; stalls = 0; holding = 0; held_c = '0; held_cy = 1'b0;
    for (int cyc = 0; cyc < 60 && rx < 8; cyc++) begin
      bus.out_ready = !(cyc >= 3 && cyc <= 5);
      if (tx < 8) begin
        bus.in_valid = 1'b1; bus.a = op_a[tx]; bus.b = op_b[tx]; bus.alu = op_m[tx];
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (bus.out_valid && !bus.out_ready) begin
        stalls++;
        n_tests++;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_in_ready: cycle %0d got %b want 0", cyc, bus.in_ready); end
        if (holding) begin
          n_tests++;
          if (bus.c !== held_c || bus.carry !== held_cy) begin
            n_fail++; $display("FAIL b2b_hold: cycle %0d got c=%h carry=%b want c=%h carry=%b", cyc, bus.c, bus.carry, held_c, held_cy);
          end
        end
        holding = 1; held_c = bus.c; held_cy = bus.carry;
      end else begin
        holding = 0;
      end
      if (bus.out_valid && bus.out_ready) begin
        n_tests++;
        if (rx >= 8) begin
          n_fail++; $display("FAIL b2b_extra: got unexpected result c=%h want none", bus.c);
        end else if (bus.c !== exp_c[rx] || bus.carry !== exp_cy[rx]) begin
          n_fail++; $display("FAIL b2b_op%0d: got c=%h carry=%b want c=%h carry=%b", rx, bus.c, bus.carry, exp_c[rx], exp_cy[rx]);
        end else begin
          $display("[TB] b2b op%0d alu=%0d c=%h carry=%b", rx, op_m[rx], bus.c, bus.carry);
        end
        rx++;
      end
      acc = bus.in_valid && bus.in_ready;
      tick();
      if (acc) tx++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    n_tests++;
    if (rx != 8 || tx != 8) begin n_fail++; $display("FAIL b2b_count: got sent=%0d received=%0d want 8/8", tx, rx); end
    n_tests++;
    if (stalls != 3) begin n_fail++; $display("FAIL b2b_stalls: got %0d stalled cycles want 3", stalls); end
    repeat (3) tick();
    n_tests++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: out_valid got %b want 0", bus.out_valid); end
  endtask

  task automatic test_flush();
    int seen;
    int lat;
    bus.out_ready = 1'b1;
    bus.a = 32'h000000F0; bus.b = 5'd4; bus.alu = ALU_SRL; bus.in_valid = 1'b1;
    tick();
    bus.a = 32'h00000001; bus.b = 5'd1; bus.alu = ALU_SLL; bus.in_valid = 1'b1;
    flush = 1'b1;
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b want 1", bus.in_ready); end
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (bus.out_valid) seen++;
      tick();
    end
    n_tests++;
    if (seen != 0) begin n_fail++; $display("FAIL flush_kill: got %0d valid outputs want 0", seen); end
    bus.a = 32'h00000180; bus.b = 5'd8; bus.alu = ALU_SRL; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 8) begin tick(); lat++; end
    n_tests++;
    if (lat != 1 || bus.c !== 32'h00000001 || bus.carry !== 1'b1) begin
      n_fail++; $display("FAIL flush_next: got lat=%0d c=%h carry=%b want lat=1 c=00000001 carry=1", lat, bus.c, bus.carry);
    end
    tick();
    $display("[TB] flush: killed in-flight and offered op, next op c=%h", 32'h00000001);
  endtask

  task automatic test_async_reset();
    int lat;
    bus.out_ready = 1'b1;
    bus.a = 32'h0000000F; bus.b = 5'd4; bus.alu = ALU_SLL; bus.in_valid = 1'b1;
    tick();
    bus.a = 32'h80000000; bus.b = 5'd4; bus.alu = ALU_SRA;
    tick();
    bus.in_valid = 1'b0;
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.c !== 32'h000000F0) begin
      n_fail++; $display("FAIL arst_pre: got valid=%b c=%h want valid=1 c=000000f0", bus.out_valid, bus.c);
    end
    #3 rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.c !== 32'h0 || bus.carry !== 1'b0) begin
      n_fail++; $display("FAIL arst_immediate: got valid=%b c=%h carry=%b want 0/00000000/0", bus.out_valid, bus.c, bus.carry);
    end
    #2 rst_n = 1'b1;
    tick();
    n_tests++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_discard1: out_valid got %b want 0", bus.out_valid); end
    tick();
    n_tests++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_discard2: out_valid got %b want 0", bus.out_valid); end
    bus.a = 32'h80000001; bus.b = 5'd1; bus.alu = ALU_SRA; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 8) begin tick(); lat++; end
    n_tests++;
    if (lat != 1 || bus.c !== 32'hC0000000 || bus.carry !== 1'b1) begin
      n_fail++; $display("FAIL arst_resume: got lat=%0d c=%h carry=%b want lat=1 c=c0000000 carry=1", lat, bus.c, bus.carry);
    end
    tick();
    $display("[TB] async reset: in-flight ops discarded, resume ok");
  endtask

  task automatic test_stage_sweep();
    logic [WIDTH:0]   exp;
    logic [WIDTH-1:0] gc [NSW];
    logic             gy [NSW];
    int               cnt [NSW];
    int               firstk [NSW];
    for (int v = 0; v < 10; v++) begin
      if (v == 0) begin
        sw_a = 32'hDEADBEEF; sw_b = 5'd0; sw_alu = ALU_ROR;
      end else if (v == 1) begin
        sw_a = 32'h80000000; sw_b = 5'd31; sw_alu = ALU_SRA;
      end else begin
        sw_a = $urandom; sw_b = 5'($urandom_range(0, 31)); sw_alu = 2'($urandom_range(0, 3));
      end
      exp = ref_shift(sw_a, sw_b, sw_alu);
      for (int s = 0; s < NSW; s++) begin cnt[s] = 0; firstk[s] = -1; gc[s] = '0; gy[s] = 1'b0; end
      sw_valid = 1'b1;
      tick();
      sw_valid = 1'b0;
      for (int k = 0; k < 7; k++) begin
        for (int s = 0; s < NSW; s++) begin
          if (sw_ov[s]) begin
            if (cnt[s] == 0) begin firstk[s] = k; gc[s] = sw_c[s]; gy[s] = sw_cy[s]; end
            cnt[s]++;
          end
        end
        tick();
      end
      for (int s = 0; s < NSW; s++) begin
        n_tests++;
        if (cnt[s] != 1 || firstk[s] != s) begin
          n_fail++; $display("FAIL sweep_v%0d_s%0d_timing: got count=%0d at=%0d want count=1 at=%0d", v, s + 1, cnt[s], firstk[s], s);
        end
        n_tests++;
        if (gc[s] !== exp[WIDTH-1:0] || gy[s] !== exp[WIDTH]) begin
          n_fail++; $display("FAIL sweep_v%0d_s%0d_result: got c=%h carry=%b want c=%h carry=%b", v, s + 1, gc[s], gy[s], exp[WIDTH-1:0], exp[WIDTH]);
        end
      end
      $display("[TB] sweep a=%h b=%0d alu=%0d -> c=%h carry=%b", sw_a, sw_b, sw_alu, exp[WIDTH-1:0], exp[WIDTH]);
    end
    n_tests++;
    if (sw_ir[NSW-1] !== 1'b1) begin n_fail++; $display("FAIL sweep_idle_ready: got %b want 1", sw_ir[NSW-1]); end
  endtask

  initial begin
    test_reset();
    test_modes();
    test_boundaries();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_stage_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
